// File: rtl/uart_word_bridge_pkg.sv
// Shared definitions for the UART word bridge: lane/word widths, the read and
// TX FSM encodings, and a byte-lane selector used by the serializer.
package uart_word_bridge_pkg;

  localparam int LANE_W = 8;
  localparam int WORD_W = 4 * LANE_W;

  typedef enum logic [1:0] {
    R_IDLE,
    R_RESP,
    R_WAIT_LOW
  } read_state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_SEND,
    T_DONE
  } tx_state_t;

  // Little-endian lane k occupies bits [8k+7:8k].
  function automatic logic [LANE_W-1:0] lane_of(input logic [WORD_W-1:0] word,
                                                input logic [1:0]        idx);
    return word[idx*LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/uart_word_bridge_word_fifo.sv
// Synchronous first-word-fall-through FIFO. A push while full is accepted only
// when a pop happens at the same edge; pops while empty are ignored.
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, so the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_word_bridge.sv
// Packs UART RX bytes into 32-bit little-endian words behind a FIFO with a
// read handshake, and serializes 32-bit response words to the TX PHY.
module uart_word_bridge
  import uart_word_bridge_pkg::*;
#(
  parameter int RX_FIFO_DEPTH       = 4,
  parameter int BYTE_TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_byte_valid,
  input  logic [LANE_W-1:0] rx_byte,
  output logic              tx_byte_valid,
  output logic [LANE_W-1:0] tx_byte,
  input  logic              tx_byte_ready,
  output logic              uart_rx_empty,
  output logic              uart_tx_empty,
  input  logic              uart_read,
  output logic              uart_read_response,
  output logic [WORD_W-1:0] uart_read_data,
  input  logic              uart_write,
  input  logic [WORD_W-1:0] uart_write_data,
  output logic              uart_write_response,
  output logic              rx_overflow
);

  localparam int TW = (BYTE_TIMEOUT_CYCLES > 1) ? $clog2(BYTE_TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(BYTE_TIMEOUT_CYCLES - 1);

  logic [1:0]          byte_idx;
  logic [3*LANE_W-1:0] lanes;
  logic [TW-1:0]       idle_cnt;
  logic                timeout_hit;
  logic                rx_push;
  logic                rd_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [WORD_W-1:0]   fifo_head;

  read_state_t         rd_state, rd_next;
  tx_state_t           tx_state, tx_next;
  logic [WORD_W-1:0]   tx_word;
  logic [1:0]          tx_idx;

  assign timeout_hit = (BYTE_TIMEOUT_CYCLES != 0) && (byte_idx != 2'd0) && (idle_cnt == T_LAST);
  assign rx_push     = rx_byte_valid && (byte_idx == 2'd3);

  // NOTE: every clocked process uses non-blocking assignments so all state
  // updates at an edge see the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx <= '0;
      lanes    <= '0;
      idle_cnt <= '0;
    end else if (rx_byte_valid) begin
      byte_idx <= byte_idx + 2'd1;
      idle_cnt <= '0;
      case (byte_idx)
        2'd0:    lanes[0*LANE_W +: LANE_W] <= rx_byte;
        2'd1:    lanes[1*LANE_W +: LANE_W] <= rx_byte;
        2'd2:    lanes[2*LANE_W +: LANE_W] <= rx_byte;
        default: ;
      endcase
    end else if (timeout_hit) begin
      byte_idx <= '0;
      idle_cnt <= '0;
    end else if (byte_idx != 2'd0) begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              rx_overflow <= 1'b0;
    else if (rx_push && fifo_full && !rd_pop) rx_overflow <= 1'b1;
  end

  word_fifo #(
    .WIDTH(WORD_W),
    .DEPTH(RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (rx_push),
    .push_data({rx_byte, lanes}),
    .pop      (rd_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  assign uart_rx_empty  = fifo_empty;
  assign uart_read_data = fifo_empty ? '0 : fifo_head;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_state <= R_IDLE;
    else        rd_state <= rd_next;
  end

  // NOTE: every output of a combinational block is defaulted first, so no
  // branch can leave a value unassigned and infer a latch.
  always_comb begin
    rd_next            = rd_state;
    rd_pop             = 1'b0;
    uart_read_response = 1'b0;
    case (rd_state)
      R_IDLE:     if (uart_read && !fifo_empty) rd_next = R_RESP;
      R_RESP: begin
        uart_read_response = 1'b1;
        rd_pop             = 1'b1;
        rd_next            = R_WAIT_LOW;
      end
      R_WAIT_LOW: if (!uart_read) rd_next = R_IDLE;
      default:    rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tx_state <= T_IDLE;
    else        tx_state <= tx_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_word <= '0;
      tx_idx  <= '0;
    end else if (tx_state == T_IDLE && uart_write) begin
      tx_word <= uart_write_data;
      tx_idx  <= '0;
    end else if (tx_state == T_SEND && tx_byte_ready) begin
      tx_idx  <= tx_idx + 2'd1;
    end
  end

  always_comb begin
    tx_next             = tx_state;
    tx_byte_valid       = 1'b0;
    tx_byte             = '0;
    uart_tx_empty       = 1'b0;
    uart_write_response = 1'b0;
    case (tx_state)
      T_IDLE: begin
        uart_tx_empty = 1'b1;
        if (uart_write) tx_next = T_SEND;
      end
      T_SEND: begin
        tx_byte_valid = 1'b1;
        tx_byte       = lane_of(tx_word, tx_idx);
        if (tx_byte_ready && tx_idx == 2'd3) tx_next = T_DONE;
      end
      T_DONE: begin
        uart_write_response = 1'b1;
        tx_next             = T_IDLE;
      end
      default: tx_next = T_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_word_bridge.sv
// Self-checking bench for uart_word_bridge: table-driven RX/TX vectors, corner
// sequences (overflow, timeout, full-with-pop, reset mid-TX) and a random RX run.
module tb_uart_word_bridge;

  localparam int DEPTH = 4;
  localparam int TMO   = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_byte_valid = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        tx_byte_valid;
  logic [7:0]  tx_byte;
  logic        tx_byte_ready = 1'b0;
  logic        uart_rx_empty;
  logic        uart_tx_empty;
  logic        uart_read = 1'b0;
  logic        uart_read_response;
  logic [31:0] uart_read_data;
  logic        uart_write = 1'b0;
  logic [31:0] uart_write_data = '0;
  logic        uart_write_response;
  logic        rx_overflow;

  always #5 clk = ~clk;

  uart_word_bridge #(
    .RX_FIFO_DEPTH      (DEPTH),
    .BYTE_TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .rx_byte_valid      (rx_byte_valid),
    .rx_byte            (rx_byte),
    .tx_byte_valid      (tx_byte_valid),
    .tx_byte            (tx_byte),
    .tx_byte_ready      (tx_byte_ready),
    .uart_rx_empty      (uart_rx_empty),
    .uart_tx_empty      (uart_tx_empty),
    .uart_read          (uart_read),
    .uart_read_response (uart_read_response),
    .uart_read_data     (uart_read_data),
    .uart_write         (uart_write),
    .uart_write_data    (uart_write_data),
    .uart_write_response(uart_write_response),
    .rx_overflow        (rx_overflow)
  );

  int         total = 0;
  int         bad = 0;
  int         rsp_cnt = 0;
  int         wr_rsp_cnt = 0;
  int         stall_err = 0;
  bit         ready_toggle = 1'b0;
  bit         stall_pending = 1'b0;
  logic [7:0] stall_byte = '0;
  logic [7:0] tx_seen [$];

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] word;
  } rx_vec_t;

  typedef struct {
    logic [31:0] word;
    bit          toggle;
    logic [7:0]  e0, e1, e2, e3;
    int          lat;
  } tx_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Samples the current cycle (values settled since the last edge), then
  // advances to the next falling edge where inputs may change.
  task automatic step();
    if (stall_pending && (!tx_byte_valid || tx_byte !== stall_byte)) stall_err++;
    stall_pending = 1'b0;
    if (reset && tx_byte_valid && tx_byte_ready) tx_seen.push_back(tx_byte);
    if (reset && tx_byte_valid && !tx_byte_ready) begin
      stall_pending = 1'b1;
      stall_byte    = tx_byte;
    end
    if (uart_read_response)  rsp_cnt++;
    if (uart_write_response) wr_rsp_cnt++;
    @(negedge clk);
    if (ready_toggle) tx_byte_ready = ~tx_byte_ready;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte_valid = 1'b1;
    rx_byte       = b;
    step();
    rx_byte_valid = 1'b0;
    rx_byte       = '0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic read_word(output logic [31:0] d, output bit got);
    d = '0;
    got = 1'b0;
    uart_read = 1'b1;
    for (int c = 0; c < 16; c++) begin
      step();
      if (uart_read_response) begin
        d   = uart_read_data;
        got = 1'b1;
        break;
      end
    end
    step();
    uart_read = 1'b0;
    step();
  endtask

  task automatic read_expect(input string name, input logic [31:0] exp);
    logic [31:0] d;
    bit          got;
    read_word(d, got);
    check({name, " got_response"}, 32'(got), 32'd1);
    check({name, " data"}, d, exp);
  endtask

  task automatic write_word(input logic [31:0] w, output int lat);
    lat = -1;
    uart_write      = 1'b1;
    uart_write_data = w;
    step();
    uart_write = 1'b0;
    for (int c = 1; c < 40; c++) begin
      if (uart_write_response) begin
        lat = c;
        break;
      end
      step();
    end
    step();
  endtask

  task automatic do_reset();
    rx_byte_valid = 1'b0;
    uart_read     = 1'b0;
    uart_write    = 1'b0;
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rx_vec_t     rx_tab [3];
    tx_vec_t     tx_tab [4];
    logic [31:0] d;
    logic [31:0] wq [$];
    logic [31:0] w;
    bit          m_ovf;
    int          lat, r0, w0;

    rx_tab[0] = '{8'h70, 8'h00, 8'h00, 8'h00, 32'h0000_0070};
    rx_tab[1] = '{8'h41, 8'h01, 8'h02, 8'h03, 32'h0302_0141};
    rx_tab[2] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 32'hDEAD_BEEF};

    tx_tab[0] = '{32'h7700_006A, 1'b0, 8'h6A, 8'h00, 8'h00, 8'h77, 5};
    tx_tab[1] = '{32'h7700_006A, 1'b1, 8'h6A, 8'h00, 8'h00, 8'h77, 9};
    tx_tab[2] = '{32'hDEAD_BEEF, 1'b0, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 5};
    tx_tab[3] = '{32'h1234_5678, 1'b1, 8'h78, 8'h56, 8'h34, 8'h12, 9};

    // Reset state
    idle(2);
    check("reset rx_empty",      32'(uart_rx_empty),       32'd1);
    check("reset tx_empty",      32'(uart_tx_empty),       32'd1);
    check("reset tx_valid",      32'(tx_byte_valid),       32'd0);
    check("reset tx_byte",       32'(tx_byte),             32'd0);
    check("reset read_resp",     32'(uart_read_response),  32'd0);
    check("reset read_data",     uart_read_data,           32'd0);
    check("reset write_resp",    32'(uart_write_response), 32'd0);
    check("reset overflow",      32'(rx_overflow),         32'd0);
    reset = 1'b1;
    step();

    // RX packing with read held for 3 cycles: exactly one response
    send_word(32'h0000_0070);
    check("pack rx_empty falls", 32'(uart_rx_empty), 32'd0);
    r0 = rsp_cnt;
    uart_read = 1'b1;
    step();
    check("hold3 resp pulse", 32'(uart_read_response), 32'd1);
    check("hold3 data",       uart_read_data,          32'h0000_0070);
    idle(2);
    uart_read = 1'b0;
    idle(2);
    check("hold3 resp count", 32'(rsp_cnt - r0),    32'd1);
    check("hold3 rx_empty",   32'(uart_rx_empty),   32'd1);

    // RX table
    for (int i = 0; i < 3; i++) begin
      send_byte(rx_tab[i].b0); idle(i);
      send_byte(rx_tab[i].b1); idle(i);
      send_byte(rx_tab[i].b2); idle(i);
      send_byte(rx_tab[i].b3);
      check($sformatf("rx_tab[%0d] not empty", i), 32'(uart_rx_empty), 32'd0);
      read_expect($sformatf("rx_tab[%0d]", i), rx_tab[i].word);
      check($sformatf("rx_tab[%0d] empty", i), 32'(uart_rx_empty), 32'd1);
    end

    // TX table, ready high or toggling every cycle
    for (int i = 0; i < 4; i++) begin
      tx_byte_ready = 1'b1;
      ready_toggle  = tx_tab[i].toggle;
      tx_seen.delete();
      w0 = wr_rsp_cnt;
      write_word(tx_tab[i].word, lat);
      ready_toggle  = 1'b0;
      tx_byte_ready = 1'b1;
      check($sformatf("tx_tab[%0d] nbytes", i), 32'(tx_seen.size()), 32'd4);
      if (tx_seen.size() == 4) begin
        check($sformatf("tx_tab[%0d] byte0", i), 32'(tx_seen[0]), 32'(tx_tab[i].e0));
        check($sformatf("tx_tab[%0d] byte1", i), 32'(tx_seen[1]), 32'(tx_tab[i].e1));
        check($sformatf("tx_tab[%0d] byte2", i), 32'(tx_seen[2]), 32'(tx_tab[i].e2));
        check($sformatf("tx_tab[%0d] byte3", i), 32'(tx_seen[3]), 32'(tx_tab[i].e3));
      end
      check($sformatf("tx_tab[%0d] latency", i), 32'(lat), 32'(tx_tab[i].lat));
      check($sformatf("tx_tab[%0d] resp count", i), 32'(wr_rsp_cnt - w0), 32'd1);
      check($sformatf("tx_tab[%0d] tx_empty", i), 32'(uart_tx_empty), 32'd1);
    end
    check("tx stall stability", 32'(stall_err), 32'd0);

    // Busy write ignored
    tx_seen.delete();
    tx_byte_ready   = 1'b0;
    uart_write      = 1'b1;
    uart_write_data = 32'h0403_0201;
    step();
    uart_write_data = 32'hFFFF_FFFF;
    step();
    uart_write = 1'b0;
    tx_byte_ready = 1'b1;
    idle(8);
    check("busy nbytes", 32'(tx_seen.size()), 32'd4);
    if (tx_seen.size() == 4)
      check("busy word", {tx_seen[3], tx_seen[2], tx_seen[1], tx_seen[0]}, 32'h0403_0201);

    // Overflow: DEPTH+1 words, no reads
    do_reset();
    for (int k = 0; k <= DEPTH; k++) send_word(32'hA500_0000 + 32'(k));
    check("ovf flag", 32'(rx_overflow), 32'd1);
    for (int k = 0; k < DEPTH; k++) read_expect($sformatf("ovf read%0d", k), 32'hA500_0000 + 32'(k));
    check("ovf extra absent", 32'(uart_rx_empty), 32'd1);

    // Timeout discards a partial word
    do_reset();
    send_byte(8'hAA);
    send_byte(8'hBB);
    idle(12);
    send_byte(8'h41); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    read_expect("timeout word", 32'h0302_0141);
    check("timeout only word", 32'(uart_rx_empty), 32'd1);
    check("timeout no ovf",    32'(rx_overflow),   32'd0);

    // Full FIFO: 4th byte of a new word lands on the popping edge
    do_reset();
    for (int k = 0; k < DEPTH; k++) send_word(32'hC000_0010 + 32'(k));
    w = 32'hC000_00FF;
    send_byte(w[7:0]); send_byte(w[15:8]); send_byte(w[23:16]);
    uart_read = 1'b1;
    step();
    d = uart_read_data;
    check("fullpop resp", 32'(uart_read_response), 32'd1);
    rx_byte_valid = 1'b1;
    rx_byte       = w[31:24];
    step();
    rx_byte_valid = 1'b0;
    uart_read     = 1'b0;
    step();
    check("fullpop head",   d,                  32'hC000_0010);
    check("fullpop no ovf", 32'(rx_overflow),   32'd0);
    for (int k = 1; k < DEPTH; k++) read_expect($sformatf("fullpop read%0d", k), 32'hC000_0010 + 32'(k));
    read_expect("fullpop new word", w);
    check("fullpop drained", 32'(uart_rx_empty), 32'd1);

    // Reset mid-TX after the second byte
    do_reset();
    tx_byte_ready = 1'b1;
    tx_seen.delete();
    w0 = wr_rsp_cnt;
    uart_write      = 1'b1;
    uart_write_data = 32'hA1B2_C3D4;
    step();
    uart_write = 1'b0;
    idle(2);
    check("midtx bytes before reset", 32'(tx_seen.size()), 32'd2);
    reset = 1'b0;
    #1;
    check("midtx valid drops", 32'(tx_byte_valid), 32'd0);
    check("midtx tx_empty",    32'(uart_tx_empty), 32'd1);
    idle(3);
    reset = 1'b1;
    idle(3);
    check("midtx no response", 32'(wr_rsp_cnt - w0), 32'd0);
    tx_seen.delete();
    write_word(32'hA1B2_C3D4, lat);
    check("midtx resend nbytes", 32'(tx_seen.size()), 32'd4);
    if (tx_seen.size() == 4)
      check("midtx resend word", {tx_seen[3], tx_seen[2], tx_seen[1], tx_seen[0]}, 32'hA1B2_C3D4);
    check("midtx resend latency", 32'(lat), 32'd5);

    // Random RX traffic against a queue model
    do_reset();
    wq.delete();
    m_ovf = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        int k = int'($urandom_range(1, 3));
        for (int j = 0; j < k; j++) begin
          send_byte(8'($urandom));
          idle(int'($urandom_range(0, 2)));
        end
        idle(TMO + 3 + int'($urandom_range(0, 4)));
      end
      w = $urandom;
      for (int j = 0; j < 4; j++) begin
        send_byte(w[8*j +: 8]);
        if (j < 3) idle(int'($urandom_range(0, 3)));
      end
      if (wq.size() < DEPTH) wq.push_back(w);
      else m_ovf = 1'b1;
      if ($urandom_range(0, 1) == 1 && wq.size() > 0)
        read_expect($sformatf("rand read n=%0d", n), wq.pop_front());
    end
    check("rand overflow", 32'(rx_overflow), 32'(m_ovf));
    while (wq.size() > 0) read_expect("rand drain", wq.pop_front());
    check("rand drained", 32'(uart_rx_empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
